data_memory_arbiter: RTL and testbench

//  Shares the single-port data memory block RAM between two requesters: port A (CPU load/store

---
 rtl/data_memory_arbiter_pkg.sv | 13 +
 rtl/data_memory_arbiter_if.sv | 21 ++
 rtl/data_memory_arbiter_rr_arbiter2.sv | 24 ++
 rtl/data_memory_arbiter.sv | 71 +++++++
 tb/tb_data_memory_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared widths, burst limit, lock-FSM state encoding and range-check helper.
//   WORD_SIZE       data/address word width
//   DMEM_ADDR_BITS  implemented memory depth = 2**DMEM_ADDR_BITS words
//   DMEM_BURST_MAX  max consecutive B grants under lock while A waits
package data_memory_arbiter_pkg;
    localparam int WORD_SIZE      = 16;
    localparam int DMEM_ADDR_BITS = 10;
    localparam int DMEM_BURST_MAX = 8;
    typedef enum logic {ST_IDLE, ST_LOCK_B} state_t;
    function automatic logic out_of_range(input logic [WORD_SIZE-1:0] addr, input int addr_bits);
        return (addr >> addr_bits) != '0;
    endfunction
endpackage

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: bundles both requester ports and the data_memory pins.
//   slave  : arbiter view (takes requests and memout, drives acks, read returns, memory pins)
//   master : requesters plus memory view (drives requests and memout)
interface data_memory_arbiter_if import data_memory_arbiter_pkg::*; ();
    logic                 a_req, a_we, a_ack, a_err, a_rvalid;
    logic [WORD_SIZE-1:0] a_addr, a_wdata, a_rdata;
    logic                 b_req, b_we, b_lock, b_ack, b_err, b_rvalid;
    logic [WORD_SIZE-1:0] b_addr, b_wdata, b_rdata;
    logic [WORD_SIZE-1:0] memaddr, memval, memout;
    logic                 memget, memset;
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_lock, b_addr, b_wdata, memout,
        output a_ack, a_err, a_rvalid, a_rdata, b_ack, b_err, b_rvalid, b_rdata,
        output memaddr, memval, memget, memset
    );
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_lock, b_addr, b_wdata, memout,
        input  a_ack, a_err, a_rvalid, a_rdata, b_ack, b_err, b_rvalid, b_rdata,
        input  memaddr, memval, memget, memset
    );
endinterface

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a registered last-grant pointer.
//   clk, reset        clock, synchronous active-high reset (pointer favours A)
//   a_req, b_req      requests
//   force_b           gives B priority (lock held by B)
//   grant_a, grant_b  combinational one-hot-or-zero grants
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    input  logic force_b,
    output logic grant_a,
    output logic grant_b
);
    logic last_a;
    // On conflict A loses only if B is forced or A won last time.
    assign grant_a = a_req && !(b_req && (force_b || last_a));
    assign grant_b = b_req && !grant_a;
    always_ff @(posedge clk) begin
        if (reset) last_a <= 1'b0;
        else if (grant_a) last_a <= 1'b1;
        else if (grant_b) last_a <= 1'b0;
    end
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the single-port data memory between requester A and B with
// round-robin grant, bounded B burst lock, range checking and owner-tagged read return.
//   clk, reset  clock, synchronous active-high reset
//   bus         data_memory_arbiter_if.slave (A/B request ports and data_memory pins)
module data_memory_arbiter import data_memory_arbiter_pkg::*; #(
    parameter int ADDR_BITS = DMEM_ADDR_BITS,
    parameter int BURST_MAX = DMEM_BURST_MAX
) (
    input  logic                        clk,
    input  logic                        reset,
    data_memory_arbiter_if.slave        bus
);
    localparam int CW = $clog2(BURST_MAX + 1);
    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic          grant_a, grant_b, err_a, err_b, sel_err, last_cnt;
    logic          rd_a, rd_b, rd_err;
    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .a_req   (bus.a_req),
        .b_req   (bus.b_req),
        .force_b (state == ST_LOCK_B),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );
    assign err_a    = out_of_range(bus.a_addr, ADDR_BITS);
    assign err_b    = out_of_range(bus.b_addr, ADDR_BITS);
    assign sel_err  = grant_a ? err_a : grant_b && err_b;
    assign last_cnt = burst_cnt >= CW'(BURST_MAX - 1);
    assign bus.a_ack   = grant_a;
    assign bus.b_ack   = grant_b;
    assign bus.a_err   = grant_a && err_a;
    assign bus.b_err   = grant_b && err_b;
    assign bus.memaddr = grant_a ? bus.a_addr  : grant_b ? bus.b_addr  : '0;
    assign bus.memval  = grant_a ? bus.a_wdata : grant_b ? bus.b_wdata : '0;
    assign bus.memset  = grant_a ? bus.a_we && !err_a  : grant_b && bus.b_we && !err_b;
    assign bus.memget  = grant_a ? !bus.a_we && !err_a : grant_b && !bus.b_we && !err_b;
    // Read return: memout arrives one cycle after memget, routed to the tagged owner only.
    assign bus.a_rvalid = rd_a;
    assign bus.b_rvalid = rd_b;
    assign bus.a_rdata  = (rd_a && !rd_err) ? bus.memout : '0;
    assign bus.b_rdata  = (rd_b && !rd_err) ? bus.memout : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            rd_a      <= 1'b0;
            rd_b      <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            rd_a   <= grant_a && !bus.a_we;
            rd_b   <= grant_b && !bus.b_we;
            rd_err <= sel_err;
            case (state)
                // The entering grant counts as the first B grant of the burst.
                ST_IDLE: if (grant_b && bus.b_lock && !(bus.a_req && BURST_MAX == 1)) begin
                    state     <= ST_LOCK_B;
                    burst_cnt <= CW'(1);
                end
                // The limit cycle still grants B; A wins next cycle via the round-robin pointer.
                default: if (!bus.b_req || !bus.b_lock || (bus.a_req && last_cnt)) begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end else if (!last_cnt) begin
                    burst_cnt <= burst_cnt + CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed bench with a behavioural data_memory model.
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [WORD_SIZE-1:0] mem [0:(1<<DMEM_ADDR_BITS)-1];
    data_memory_arbiter_if bus ();
    data_memory_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.memset) mem[bus.memaddr[DMEM_ADDR_BITS-1:0]] <= bus.memval;
        if (bus.memget) bus.memout <= mem[bus.memaddr[DMEM_ADDR_BITS-1:0]];
    end

    task automatic idle_inputs();
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus.a_ack, bus.b_ack, bus.memget, bus.memset, bus.a_rvalid, bus.b_rvalid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {bus.a_ack, bus.b_ack, bus.memget, bus.memset, bus.a_rvalid, bus.b_rvalid});
        end
        checks++;
        if (bus.memaddr !== 16'h0 || bus.memval !== 16'h0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h val=%h exp 0000/0000", bus.memaddr, bus.memval);
        end
    endtask

    task automatic test_read();
        do_reset();
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0005;
        #1;
        checks++;
        if ({bus.a_ack, bus.b_ack, bus.memget, bus.memset, bus.a_err} !== 5'b10100) begin
            failures++;
            $display("FAIL read_issue got=%b exp=10100", {bus.a_ack, bus.b_ack, bus.memget, bus.memset, bus.a_err});
        end
        checks++;
        if (bus.memaddr !== 16'h0005) begin
            failures++;
            $display("FAIL read_addr got=%h exp=0005", bus.memaddr);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 16'h1234 || bus.b_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL read_return got rv=%b data=%h brv=%b exp rv=1 data=1234 brv=0",
                     bus.a_rvalid, bus.a_rdata, bus.b_rvalid);
        end
        @(negedge clk);
        checks++;
        if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 16'h0) begin
            failures++;
            $display("FAIL read_after got rv=%b data=%h exp rv=0 data=0000", bus.a_rvalid, bus.a_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0030; bus.a_wdata = 16'h1111;
        #1;
        checks++;
        if ({bus.a_ack, bus.b_ack} !== 2'b10) begin
            failures++;
            $display("FAIL rr_first got=%b exp=10", {bus.a_ack, bus.b_ack});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0031;
            bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0032; bus.b_lock = 0;
            #1;
            checks++;
            if ({bus.a_ack, bus.b_ack} !== exp_seq[i]) begin
                failures++;
                $display("FAIL rr_cycle%0d got ab=%b exp ab=%b", i, {bus.a_ack, bus.b_ack}, exp_seq[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_burst_lock();
        int nb = 0;
        int a_at = -1;
        int b_left = 12;
        logic a_pend = 0;
        logic b_resumed = 0;
        logic both = 0;
        do_reset();
        for (int cyc = 0; cyc < 30 && b_left > 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) a_pend = 1;
            bus.a_req = a_pend; bus.a_we = 1; bus.a_addr = 16'h0040; bus.a_wdata = 16'hAAAA;
            bus.b_req = 1; bus.b_lock = 1; bus.b_we = 1; bus.b_addr = 16'h0041; bus.b_wdata = 16'(cyc);
            #1;
            if (bus.a_ack && bus.b_ack) both = 1;
            if (bus.b_ack) begin
                b_left--;
                if (a_at < 0) nb++;
                if (a_at >= 0 && cyc == a_at + 1) b_resumed = 1;
            end
            if (bus.a_ack) begin
                a_at = cyc;
                a_pend = 0;
            end
        end
        idle_inputs();
        checks++;
        if (nb != 8) begin
            failures++;
            $display("FAIL burst_b_count got=%0d exp=8", nb);
        end
        checks++;
        if (a_at != 8) begin
            failures++;
            $display("FAIL burst_a_slot got=%0d exp=8", a_at);
        end
        checks++;
        if (!b_resumed || b_left != 0) begin
            failures++;
            $display("FAIL burst_b_resume got resumed=%0b left=%0d exp resumed=1 left=0", b_resumed, b_left);
        end
        checks++;
        if (both) begin
            failures++;
            $display("FAIL burst_exclusive got both_acks=1 exp=0");
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0010; bus.a_wdata = 16'hBEEF;
        #1;
        checks++;
        if ({bus.a_ack, bus.memset, bus.memget} !== 3'b110 || bus.memval !== 16'hBEEF) begin
            failures++;
            $display("FAIL wr_issue got ack/set/get=%b val=%h exp 110 BEEF",
                     {bus.a_ack, bus.memset, bus.memget}, bus.memval);
        end
        @(negedge clk);
        idle_inputs();
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0010;
        #1;
        checks++;
        if ({bus.b_ack, bus.memget, bus.a_rvalid} !== 3'b110) begin
            failures++;
            $display("FAIL wr_rd_issue got ack/get/arv=%b exp=110", {bus.b_ack, bus.memget, bus.a_rvalid});
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 16'hBEEF || bus.a_rvalid !== 1'b0 || bus.a_rdata !== 16'h0) begin
            failures++;
            $display("FAIL wr_rd_return got brv=%b bdata=%h arv=%b adata=%h exp 1 BEEF 0 0000",
                     bus.b_rvalid, bus.b_rdata, bus.a_rvalid, bus.a_rdata);
        end
    endtask

    task automatic test_range();
        do_reset();
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0400;
        #1;
        checks++;
        if ({bus.a_ack, bus.a_err, bus.memget, bus.memset} !== 4'b1100) begin
            failures++;
            $display("FAIL range_issue got ack/err/get/set=%b exp=1100",
                     {bus.a_ack, bus.a_err, bus.memget, bus.memset});
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL range_return got rv=%b data=%h exp rv=1 data=0000", bus.a_rvalid, bus.a_rdata);
        end
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h8005; bus.b_wdata = 16'hDEAD;
        #1;
        checks++;
        if ({bus.b_ack, bus.b_err, bus.memset} !== 3'b110) begin
            failures++;
            $display("FAIL range_write got ack/err/set=%b exp=110", {bus.b_ack, bus.b_err, bus.memset});
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (mem[5] !== 16'h1234) begin
            failures++;
            $display("FAIL range_write_dropped got mem5=%h exp=1234", mem[5]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(negedge clk);
        bus.b_req = 1; bus.b_lock = 1; bus.b_we = 0; bus.b_addr = 16'h0005;
        @(negedge clk);
        bus.b_addr = 16'h0010;
        reset = 1;
        #1;
        checks++;
        if (bus.b_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_burst_grant got=%b exp=1", bus.b_ack);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.b_rvalid !== 1'b0 || bus.a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_drop_read got brv=%b arv=%b exp 0 0", bus.b_rvalid, bus.a_rvalid);
        end
        checks++;
        if (dut.state !== ST_IDLE || dut.burst_cnt !== '0) begin
            failures++;
            $display("FAIL rst_state got state=%0d cnt=%0d exp 0 0", dut.state, dut.burst_cnt);
        end
        reset = 0;
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0050;
        bus.b_req = 1; bus.b_lock = 1; bus.b_we = 1; bus.b_addr = 16'h0051;
        #1;
        checks++;
        if ({bus.a_ack, bus.b_ack} !== 2'b10) begin
            failures++;
            $display("FAIL rst_conflict got ab=%b exp=10", {bus.a_ack, bus.b_ack});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < (1 << DMEM_ADDR_BITS); i++) mem[i] = 16'(i);
        mem[5] = 16'h1234;
        idle_inputs();
        test_reset();
        test_read();
        test_round_robin();
        test_burst_lock();
        test_write_then_read();
        test_range();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
